// File: rtl/card_line_prefetch_pkg.sv
// Shared display constants for the card renderer: card geometry, card_type
// encoding, background colour and the h-blank budget the prefetcher must fit in.
package card_line_prefetch_pkg;

   localparam int          CARD_W         = 32;
   localparam int          CARD_H         = 46;
   localparam int          SUIT_SPAN      = 13;
   localparam logic [5:0]  FACE_RED       = 6'd52;
   localparam logic [5:0]  FACE_BLACK     = 6'd53;
   localparam logic [5:0]  CARD_TYPE_MAX  = 6'd53;
   localparam logic [11:0] BG_COLOR       = 12'h000;
   localparam int          H_BLANK_CYCLES = 160;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FLUSH
   } fetch_state_e;

   // Types 54..63 have no artwork in the ROM.
   function automatic logic card_drawable(input logic [5:0] card_type);
      return card_type <= CARD_TYPE_MAX;
   endfunction

endpackage

// File: rtl/card_line_prefetch_fetch_pipe.sv
// One-stage write pipe: holds the line-buffer address and background flag of the
// ROM read in flight, and selects ROM data or background when the data arrives.
module card_fetch_pipe #(
   parameter int          AW       = 7,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_i,
   input  logic          kill_i,
   input  logic [AW-1:0] addr_i,
   input  logic          use_bg_i,
   input  logic [11:0]   rom_pixel_i,
   output logic          lb_we_o,
   output logic [AW-1:0] lb_addr_o,
   output logic [11:0]   lb_data_o
);

   logic          valid_q;
   logic [AW-1:0] addr_q;
   logic          use_bg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         addr_q   <= '0;
         use_bg_q <= 1'b0;
      end else begin
         valid_q <= issue_i && !kill_i;
         if (issue_i) begin
            addr_q   <= addr_i;
            use_bg_q <= use_bg_i;
         end
      end
   end

   assign lb_we_o   = valid_q;
   assign lb_addr_o = addr_q;

   // Data is forced to zero when no write is in progress.
   always_comb begin
      lb_data_o = '0;
      if (valid_q) begin
         lb_data_o = use_bg_q ? BG_COLOR : rom_pixel_i;
      end
   end

endmodule

// File: rtl/card_line_prefetch.sv
// Scanline prefetcher: snapshots a row of card slots at line_start and streams one
// ROM read per cycle into the line buffer, slot by slot, column by column.
module card_line_prefetch #(
   parameter int          SLOTS    = 4,
   parameter int          CARD_W   = card_line_prefetch_pkg::CARD_W,
   parameter int          CARD_H   = card_line_prefetch_pkg::CARD_H,
   parameter logic [11:0] BG_COLOR = card_line_prefetch_pkg::BG_COLOR
) (
   input  logic                              clk_25MHz,
   input  logic                              rst_n,
   input  logic                              line_start,
   input  logic [9:0]                        line_y,
   input  logic [9:0]                        row_y0,
   input  logic [6*SLOTS-1:0]                slot_card,
   input  logic [SLOTS-1:0]                  slot_valid,
   output logic [5:0]                        rom_card_type,
   output logic [5:0]                        rom_pixel_x,
   output logic [5:0]                        rom_pixel_y,
   input  logic [11:0]                       rom_pixel,
   output logic                              lb_we,
   output logic [$clog2(SLOTS*CARD_W)-1:0]   lb_addr,
   output logic [11:0]                       lb_data,
   output logic                              busy,
   output logic                              done,
   output logic                              overrun
);

   import card_line_prefetch_pkg::*;

   localparam int            SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int            XW     = $clog2(CARD_W);
   localparam int            AW     = $clog2(SLOTS*CARD_W);
   localparam logic [SW-1:0] S_LAST = SW'(SLOTS-1);
   localparam logic [XW-1:0] X_LAST = XW'(CARD_W-1);

   fetch_state_e     state_q, state_d;
   logic [5:0]       slot_card_arr [SLOTS];
   logic [5:0]       snap_card_q   [SLOTS];
   logic [SLOTS-1:0] snap_valid_q;
   logic             row_hit_q, row_hit_d;
   logic [5:0]       py_q, py_d;
   logic [SW-1:0]    s_q;
   logic [XW-1:0]    x_q;
   logic             done_q, overrun_q;
   logic             overrun_d;
   logic             last_issue;
   logic             issue;
   logic             use_bg;
   logic [AW-1:0]    issue_addr;
   logic [10:0]      line_y_w, row_top_w, row_end_w;

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         assign slot_card_arr[gi] = slot_card[6*gi +: 6];

         always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
               snap_card_q[gi]  <= '0;
               snap_valid_q[gi] <= 1'b0;
            end else if (line_start) begin
               snap_card_q[gi]  <= slot_card_arr[gi];
               snap_valid_q[gi] <= slot_valid[gi];
            end
         end
      end
   endgenerate

   // Widened to 11 bits so a card row near the bottom of the frame cannot wrap.
   assign line_y_w  = {1'b0, line_y};
   assign row_top_w = {1'b0, row_y0};
   assign row_end_w = row_top_w + 11'(CARD_H);
   assign row_hit_d = (line_y_w >= row_top_w) && (line_y_w < row_end_w);
   assign py_d      = 6'(line_y - row_y0);

   assign last_issue = (state_q == ST_FETCH) && (s_q == S_LAST) && (x_q == X_LAST);
   assign overrun_d  = line_start && busy;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (line_start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (line_start)      state_d = ST_FETCH;
            else if (last_issue) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = line_start ? ST_FETCH : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != ST_IDLE);
      issue = (state_q == ST_FETCH);
   end

   // Counters park on the last column after the final issue so the ROM address
   // outputs keep their last value while idle.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         row_hit_q <= 1'b0;
         py_q      <= '0;
         s_q       <= '0;
         x_q       <= '0;
      end else if (line_start) begin
         row_hit_q <= row_hit_d;
         py_q      <= py_d;
         s_q       <= '0;
         x_q       <= '0;
      end else if (issue && !last_issue) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            s_q <= s_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q    <= (state_q == ST_FLUSH) && !line_start;
         overrun_q <= overrun_d;
      end
   end

   assign use_bg     = !row_hit_q || !snap_valid_q[s_q] || !card_drawable(snap_card_q[s_q]);
   assign issue_addr = AW'(s_q) * AW'(CARD_W) + AW'(x_q);

   assign rom_card_type = snap_card_q[s_q];
   assign rom_pixel_x   = 6'(x_q);
   assign rom_pixel_y   = py_q;

   card_fetch_pipe #(
      .AW       (AW),
      .BG_COLOR (BG_COLOR)
   ) u_pipe (
      .clk         (clk_25MHz),
      .rst_n       (rst_n),
      .issue_i     (issue),
      .kill_i      (overrun_d),
      .addr_i      (issue_addr),
      .use_bg_i    (use_bg),
      .rom_pixel_i (rom_pixel),
      .lb_we_o     (lb_we),
      .lb_addr_o   (lb_addr),
      .lb_data_o   (lb_data)
   );

   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_card_line_prefetch.sv
// Directed bench for card_line_prefetch: a behavioural card ROM feeds the DUT and
// every line-buffer write is captured and compared against hand-derived values.
module tb_card_line_prefetch;

   logic        clk_25MHz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        line_start = 1'b0;
   logic [9:0]  line_y    = '0;
   logic [9:0]  row_y0    = '0;
   logic [23:0] slot_card = '0;
   logic [3:0]  slot_valid = '0;
   logic [5:0]  rom_card_type, rom_pixel_x, rom_pixel_y;
   logic [11:0] rom_pixel;
   logic        lb_we;
   logic [6:0]  lb_addr;
   logic [11:0] lb_data;
   logic        busy, done, overrun;

   int checks   = 0;
   int failures = 0;

   int          cap_addr[$];
   int          cap_cyc[$];
   logic [11:0] cap_data[$];
   int          done_cnt, done_cyc, ovr_cnt, ovr_cyc, ybad;
   logic        rst_busy, rst_we;
   logic [23:0] alt_card;
   logic [3:0]  alt_valid;
   logic [9:0]  alt_line_y;

   always #20 clk_25MHz = ~clk_25MHz;

   card_line_prefetch #(.SLOTS(4)) dut (
      .clk_25MHz     (clk_25MHz),
      .rst_n         (rst_n),
      .line_start    (line_start),
      .line_y        (line_y),
      .row_y0        (row_y0),
      .slot_card     (slot_card),
      .slot_valid    (slot_valid),
      .rom_card_type (rom_card_type),
      .rom_pixel_x   (rom_pixel_x),
      .rom_pixel_y   (rom_pixel_y),
      .rom_pixel     (rom_pixel),
      .lb_we         (lb_we),
      .lb_addr       (lb_addr),
      .lb_data       (lb_data),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   function automatic logic [11:0] rom_f(input logic [5:0] c, input logic [5:0] x, input logic [5:0] y);
      int v;
      v = int'(c) * 37 + int'(x) * 5 + int'(y) * 131;
      return 12'(v) ^ 12'h5A5;
   endfunction

   // Registered card ROM: data appears one cycle after the address.
   always @(posedge clk_25MHz) rom_pixel <= rom_f(rom_card_type, rom_pixel_x, rom_pixel_y);

   // Expected line-buffer content for one address, from the intended snapshot.
   function automatic logic [11:0] exp_pix(input logic [23:0] cards, input logic [3:0] valid,
                                           input int ly, input int y0, input int addr);
      int         s, x;
      logic [5:0] c;
      s = addr / 32;
      x = addr % 32;
      c = cards[s*6 +: 6];
      if (ly < y0 || ly >= y0 + 46 || !valid[s] || c > 6'd53) return 12'h000;
      return rom_f(c, 6'(x), 6'(ly - y0));
   endfunction

   // Pulses line_start in cycle 0 and records everything the DUT does for ncyc cycles.
   task automatic capture(input int ncyc, input int restart_at, input int scramble_at,
                          input int rst_at, input int exp_y);
      cap_addr.delete();
      cap_cyc.delete();
      cap_data.delete();
      done_cnt = 0; done_cyc = -1; ovr_cnt = 0; ovr_cyc = -1; ybad = 0;
      rst_busy = 1'bx; rst_we = 1'bx;
      line_start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_25MHz);
         if (lb_we) begin
            cap_addr.push_back(int'(lb_addr));
            cap_data.push_back(lb_data);
            cap_cyc.push_back(c);
         end
         if (done)    begin done_cnt++; done_cyc = c; end
         if (overrun) begin ovr_cnt++;  ovr_cyc  = c; end
         if (exp_y >= 0 && busy && int'(rom_pixel_y) != exp_y) ybad++;
         line_start = (c == restart_at);
         if (c == scramble_at) begin
            slot_card  = alt_card;
            slot_valid = alt_valid;
            line_y     = alt_line_y;
         end
         if (rst_at > 0 && c == rst_at) begin
            rst_n = 1'b0;
            #1;
            rst_busy = busy;
            rst_we   = lb_we;
         end
         if (rst_at > 0 && c == rst_at + 3) rst_n = 1'b1;
      end
      line_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk_25MHz);
      checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0)          begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (overrun !== 1'b0)       begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      checks++; if (lb_we !== 1'b0)         begin failures++; $display("FAIL reset_lb_we got=%b want=0", lb_we); end
      checks++; if (lb_addr !== 7'd0)       begin failures++; $display("FAIL reset_lb_addr got=%0d want=0", lb_addr); end
      checks++; if (lb_data !== 12'h000)    begin failures++; $display("FAIL reset_lb_data got=%h want=000", lb_data); end
      checks++; if (rom_card_type !== 6'd0) begin failures++; $display("FAIL reset_rom_card got=%0d want=0", rom_card_type); end
      checks++; if (rom_pixel_x !== 6'd0)   begin failures++; $display("FAIL reset_rom_x got=%0d want=0", rom_pixel_x); end
      checks++; if (rom_pixel_y !== 6'd0)   begin failures++; $display("FAIL reset_rom_y got=%0d want=0", rom_pixel_y); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk_25MHz);
      $display("reset: outputs checked with rst_n low, reset released");
   endtask

   task automatic test_full_row();
      logic [23:0] cards;
      cards = {6'd39, 6'd26, 6'd13, 6'd0};
      slot_card = cards; slot_valid = 4'hF; row_y0 = 10'd100; line_y = 10'd110;
      // Inputs change mid-fetch; only the snapshot must matter.
      alt_card = {6'd1, 6'd2, 6'd3, 6'd4}; alt_valid = 4'h0; alt_line_y = 10'd300;
      capture(135, -1, 20, -1, 10);
      checks++; if (cap_addr.size() != 128) begin failures++; $display("FAIL full_row_count got=%0d want=128", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 128; i++) begin
         checks++;
         if (cap_addr[i] != i || cap_cyc[i] != 2 + i || cap_data[i] !== exp_pix(cards, 4'hF, 110, 100, i)) begin
            failures++;
            $display("FAIL full_row_write%0d got addr=%0d cyc=%0d data=%h want addr=%0d cyc=%0d data=%h",
                     i, cap_addr[i], cap_cyc[i], cap_data[i], i, 2 + i, exp_pix(cards, 4'hF, 110, 100, i));
         end
      end
      checks++; if (ybad != 0) begin failures++; $display("FAIL full_row_rom_y bad_cycles=%0d want=0", ybad); end
      checks++; if (done_cnt != 1 || done_cyc != 130) begin failures++; $display("FAIL full_row_done got cnt=%0d cyc=%0d want cnt=1 cyc=130", done_cnt, done_cyc); end
      checks++; if (ovr_cnt != 0) begin failures++; $display("FAIL full_row_overrun got=%0d want=0", ovr_cnt); end
      $display("full_row: %0d writes, done at cycle %0d", cap_addr.size(), done_cyc);
   endtask

   task automatic test_partial_valid();
      logic [23:0] cards;
      cards = {6'd39, 6'd26, 6'd13, 6'd0};
      slot_card = cards; slot_valid = 4'b1010; row_y0 = 10'd100; line_y = 10'd100;
      capture(133, -1, -1, -1, 0);
      checks++; if (cap_addr.size() != 128) begin failures++; $display("FAIL partial_count got=%0d want=128", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 128; i++) begin
         checks++;
         if (cap_addr[i] != i || cap_data[i] !== exp_pix(cards, 4'b1010, 100, 100, i)) begin
            failures++;
            $display("FAIL partial_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                     i, cap_addr[i], cap_data[i], i, exp_pix(cards, 4'b1010, 100, 100, i));
         end
      end
      checks++; if (cap_data.size() > 32 && cap_data[32] !== rom_f(6'd13, 6'd0, 6'd0)) begin failures++; $display("FAIL partial_slot1_x0 got=%h want=%h", cap_data[32], rom_f(6'd13, 6'd0, 6'd0)); end
      checks++; if (done_cnt != 1 || done_cyc != 130) begin failures++; $display("FAIL partial_done got cnt=%0d cyc=%0d want cnt=1 cyc=130", done_cnt, done_cyc); end
      $display("partial_valid: %0d writes, slots 0 and 2 background", cap_addr.size());
   endtask

   task automatic test_out_of_rows();
      int lys[2];
      lys[0] = 146; lys[1] = 99;
      for (int k = 0; k < 2; k++) begin
         int nbad;
         slot_card = {6'd39, 6'd26, 6'd13, 6'd0}; slot_valid = 4'hF; row_y0 = 10'd100; line_y = 10'(lys[k]);
         capture(133, -1, -1, -1, -1);
         nbad = 0;
         for (int i = 0; i < cap_data.size(); i++) if (cap_data[i] !== 12'h000) nbad++;
         checks++; if (cap_addr.size() != 128) begin failures++; $display("FAIL outside_count y=%0d got=%0d want=128", lys[k], cap_addr.size()); end
         checks++; if (nbad != 0) begin failures++; $display("FAIL outside_bg y=%0d non_bg_writes=%0d want=0", lys[k], nbad); end
         checks++; if (done_cyc != 130) begin failures++; $display("FAIL outside_done y=%0d got=%0d want=130", lys[k], done_cyc); end
         $display("out_of_rows: line_y=%0d %0d writes", lys[k], cap_addr.size());
      end
   endtask

   task automatic test_face_and_bad_type();
      logic [23:0] cards;
      cards = {6'd60, 6'd53, 6'd13, 6'd0};
      slot_card = cards; slot_valid = 4'hF; row_y0 = 10'd100; line_y = 10'd145;
      capture(133, -1, -1, -1, 45);
      checks++; if (cap_addr.size() != 128) begin failures++; $display("FAIL face_count got=%0d want=128", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 128; i++) begin
         checks++;
         if (cap_addr[i] != i || cap_data[i] !== exp_pix(cards, 4'hF, 145, 100, i)) begin
            failures++;
            $display("FAIL face_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                     i, cap_addr[i], cap_data[i], i, exp_pix(cards, 4'hF, 145, 100, i));
         end
      end
      checks++; if (cap_data.size() > 96 && cap_data[64] !== rom_f(6'd53, 6'd0, 6'd45)) begin failures++; $display("FAIL face_slot2_x0 got=%h want=%h", cap_data[64], rom_f(6'd53, 6'd0, 6'd45)); end
      checks++; if (ybad != 0) begin failures++; $display("FAIL face_rom_y bad_cycles=%0d want=0", ybad); end
      $display("face_and_bad_type: %0d writes, done at cycle %0d", cap_addr.size(), done_cyc);
   endtask

   task automatic test_overrun();
      logic [23:0] cards;
      cards = {6'd39, 6'd26, 6'd13, 6'd0};
      slot_card = cards; slot_valid = 4'hF; row_y0 = 10'd100; line_y = 10'd110;
      alt_card = {6'd7, 6'd5, 6'd53, 6'd52}; alt_valid = 4'b0111; alt_line_y = 10'd120;
      capture(190, 50, 50, -1, -1);
      checks++; if (ovr_cnt != 1 || ovr_cyc != 51) begin failures++; $display("FAIL overrun_pulse got cnt=%0d cyc=%0d want cnt=1 cyc=51", ovr_cnt, ovr_cyc); end
      checks++; if (cap_addr.size() != 177) begin failures++; $display("FAIL overrun_count got=%0d want=177", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 177; i++) begin
         int          ea, ec;
         logic [11:0] ed;
         if (i < 49) begin
            ea = i; ec = 2 + i; ed = exp_pix(cards, 4'hF, 110, 100, i);
         end else begin
            ea = i - 49; ec = 52 + ea; ed = exp_pix(alt_card, alt_valid, 120, 100, ea);
         end
         checks++;
         if (cap_addr[i] != ea || cap_cyc[i] != ec || cap_data[i] !== ed) begin
            failures++;
            $display("FAIL overrun_write%0d got addr=%0d cyc=%0d data=%h want addr=%0d cyc=%0d data=%h",
                     i, cap_addr[i], cap_cyc[i], cap_data[i], ea, ec, ed);
         end
      end
      checks++; if (done_cnt != 1 || done_cyc != 180) begin failures++; $display("FAIL overrun_done got cnt=%0d cyc=%0d want cnt=1 cyc=180", done_cnt, done_cyc); end
      $display("overrun: restart at cycle 50, %0d writes, done at cycle %0d", cap_addr.size(), done_cyc);
   endtask

   task automatic test_reset_mid_fetch();
      logic [23:0] cards;
      cards = {6'd39, 6'd26, 6'd13, 6'd0};
      slot_card = cards; slot_valid = 4'hF; row_y0 = 10'd100; line_y = 10'd110;
      capture(140, -1, -1, 70, -1);
      checks++; if (rst_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b want=0", rst_busy); end
      checks++; if (rst_we !== 1'b0)   begin failures++; $display("FAIL rst_mid_we got=%b want=0", rst_we); end
      checks++; if (done_cnt != 0)     begin failures++; $display("FAIL rst_mid_done got=%0d want=0", done_cnt); end
      checks++; if (cap_addr.size() != 69) begin failures++; $display("FAIL rst_mid_count got=%0d want=69", cap_addr.size()); end
      capture(133, -1, -1, -1, 10);
      checks++; if (cap_addr.size() != 128) begin failures++; $display("FAIL rst_clean_count got=%0d want=128", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 128; i++) begin
         checks++;
         if (cap_addr[i] != i || cap_cyc[i] != 2 + i || cap_data[i] !== exp_pix(cards, 4'hF, 110, 100, i)) begin
            failures++;
            $display("FAIL rst_clean_write%0d got addr=%0d cyc=%0d data=%h want addr=%0d cyc=%0d data=%h",
                     i, cap_addr[i], cap_cyc[i], cap_data[i], i, 2 + i, exp_pix(cards, 4'hF, 110, 100, i));
         end
      end
      checks++; if (done_cnt != 1 || done_cyc != 130) begin failures++; $display("FAIL rst_clean_done got cnt=%0d cyc=%0d want cnt=1 cyc=130", done_cnt, done_cyc); end
      $display("reset_mid_fetch: aborted line then clean line of %0d writes", cap_addr.size());
   endtask

   initial begin
      test_reset();
      test_full_row();
      test_partial_valid();
      test_out_of_rows();
      test_face_and_bad_type();
      test_overrun();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
